// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory/IO bridge.
// Holds the bridge FSM state type and the active-low seven-segment code table.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_WRITE,
        RAM_WAIT,
        RAM_SAMPLE,
        IO,
        DONE,
        RELEASE
    } bridge_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam logic [6:0]  SEG_BLANK       = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active-low; index is the hex digit value.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/slc3_mem_bridge_if.sv
// CPU-side request/ready bus between the SLC-3 datapath and the memory bridge.
// master = CPU (MAR/MDR/OE/WE), slave = bridge (MDR_rd/MEM_RDY).
interface slc3_mem_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] MAR;
    logic [DATA_W-1:0] MDR_wr;
    logic [DATA_W-1:0] MDR_rd;
    logic              MEM_OE;
    logic              MEM_WE;
    logic              MEM_RDY;

    modport master (output MAR, MDR_wr, MEM_OE, MEM_WE, input MDR_rd, MEM_RDY);
    modport slave  (input MAR, MDR_wr, MEM_OE, MEM_WE, output MDR_rd, MEM_RDY);
endinterface

// File: rtl/slc3_mem_bridge_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Only exists when SLC3_HEX_DECODE_EN is defined (the decoder is not built otherwise).
`ifdef SLC3_HEX_DECODE_EN
module hex_to_7seg
    import slc3_mem_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nibble];
endmodule
`endif

// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory/IO bridge: RAM with fixed wait states, switch/hex IO at IO_ADDR, 4-phase handshake.
// Optional macro SLC3_HEX_DECODE_EN builds registered seven-segment decoding of HEX_reg.
module slc3_mem_bridge
    import slc3_mem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    slc3_mem_bridge_if.slave  cpu,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [9:0]        SW,
    output logic [15:0]       HEX_reg,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3
);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    bridge_state_t     state, state_next;
    logic [3:0]        wait_cnt;
    logic              is_write_q;
    logic [DATA_W-1:0] mdr_rd_q;
    logic [9:0]        sw_meta, sw_sync;
    logic              req;

    assign req = cpu.MEM_WE | cpu.MEM_OE;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (cpu.MAR == IO_ADDR)  state_next = IO;
                    else if (cpu.MEM_WE)     state_next = RAM_WRITE;
                    else if (WAIT_STATES == 0) state_next = RAM_SAMPLE;
                    else                     state_next = RAM_WAIT;
                end
            end
            RAM_WRITE:  state_next = DONE;
            RAM_WAIT:   if (wait_cnt == WAIT_LAST) state_next = RAM_SAMPLE;
            RAM_SAMPLE: state_next = DONE;
            IO:         state_next = DONE;
            DONE:       state_next = RELEASE;
            RELEASE:    if (!req) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    assign cpu.MEM_RDY = (state == DONE);
    assign ram_we      = (state == RAM_WRITE);
    assign cpu.MDR_rd  = mdr_rd_q;

    // Address/data are latched at acceptance so later MAR/MDR changes cannot disturb the access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            is_write_q <= 1'b0;
            wait_cnt   <= '0;
            mdr_rd_q   <= '0;
            HEX_reg    <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            case (state)
                IDLE: begin
                    if (req) begin
                        ram_addr   <= cpu.MAR;
                        ram_wdata  <= cpu.MDR_wr;
                        is_write_q <= cpu.MEM_WE;
                        wait_cnt   <= '0;
                    end
                end
                RAM_WAIT:   wait_cnt <= wait_cnt + 4'd1;
                RAM_SAMPLE: mdr_rd_q <= ram_rdata;
                IO: begin
                    if (is_write_q) HEX_reg  <= 16'(ram_wdata);
                    else            mdr_rd_q <= DATA_W'({6'b0, sw_sync});
                end
                default: ;
            endcase
        end
    end

`ifdef SLC3_HEX_DECODE_EN
    logic [6:0] seg_d [4];

    for (genvar i = 0; i < 4; i++) begin : g_dec
        hex_to_7seg u_dec (
            .nibble (HEX_reg[4*i +: 4]),
            .seg    (seg_d[i])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            HEX0 <= SEG_LUT[0];
            HEX1 <= SEG_LUT[0];
            HEX2 <= SEG_LUT[0];
            HEX3 <= SEG_LUT[0];
        end else begin
            HEX0 <= seg_d[0];
            HEX1 <= seg_d[1];
            HEX2 <= seg_d[2];
            HEX3 <= seg_d[3];
        end
    end
`else
    assign HEX0 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
    assign HEX2 = SEG_BLANK;
    assign HEX3 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed self-checking bench for slc3_mem_bridge with a 1-cycle synchronous RAM model.
// Works with or without SLC3_HEX_DECODE_EN defined.
module tb_slc3_mem_bridge;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    slc3_mem_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    logic [15:0] ram_addr, ram_wdata, ram_rdata, HEX_reg;
    logic        ram_we;
    logic [9:0]  SW;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    slc3_mem_bridge #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .SW        (SW),
        .HEX_reg   (HEX_reg),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3)
    );

`ifdef SLC3_HEX_DECODE_EN
    localparam logic [27:0] HEX_RST   = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] HEX_C0DE  = {7'h46, 7'h40, 7'h21, 7'h06};
`else
    localparam logic [27:0] HEX_RST   = {4{7'h7F}};
    localparam logic [27:0] HEX_C0DE  = {4{7'h7F}};
`endif

    // Synchronous RAM model; cleared and preloaded while Reset is high.
    logic [15:0] mem [65536];
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            mem[16'h0010] <= 16'h1234;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int rdy_cnt = 0;
    int we_cnt  = 0;
    always @(negedge Clk) begin
        if (bus.MEM_RDY) rdy_cnt++;
        if (ram_we)      we_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive a request, count cycles to MEM_RDY (bounded), then release the handshake.
    task automatic access(input logic we, input logic oe, input logic [15:0] addr,
                          input logic [15:0] data, output int lat, output logic [15:0] rd);
        bus.MAR    = addr;
        bus.MDR_wr = data;
        bus.MEM_WE = we;
        bus.MEM_OE = oe;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.MEM_RDY && lat < 40);
        rd = bus.MDR_rd;
        bus.MEM_WE = 1'b0;
        bus.MEM_OE = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, n, w0, r0;
        logic [15:0] rd;

        Reset = 1'b1;
        bus.MAR = '0; bus.MDR_wr = '0; bus.MEM_OE = 1'b0; bus.MEM_WE = 1'b0;
        SW = '0;
        tick();
        tick();
        check("rst_rdy",   32'(bus.MEM_RDY), 32'd0);
        check("rst_we",    32'(ram_we), 32'd0);
        check("rst_hexreg", 32'(HEX_reg), 32'h0);
        check("rst_mdr",   32'(bus.MDR_rd), 32'h0);
        check("rst_addr",  32'(ram_addr), 32'h0);
        check("rst_hexseg", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(HEX_RST));
        Reset = 1'b0;
        tick();

        // RAM read with two wait states
        access(1'b0, 1'b1, 16'h0010, 16'h0000, lat, rd);
        check("rd_lat",  32'(lat), 32'd4);
        check("rd_data", 32'(rd), 32'h1234);

        // RAM write then readback
        w0 = we_cnt;
        access(1'b1, 1'b0, 16'h0020, 16'hBEEF, lat, rd);
        check("wr_lat",  32'(lat), 32'd2);
        check("wr_pulses", 32'(we_cnt - w0), 32'd1);
        check("wr_mem",  32'(mem[16'h0020]), 32'hBEEF);
        access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd);
        check("rb_lat",  32'(lat), 32'd4);
        check("rb_data", 32'(rd), 32'hBEEF);

        // MAR/MDR changes after acceptance are ignored
        bus.MAR = 16'h0030; bus.MDR_wr = 16'h5555; bus.MEM_WE = 1'b1;
        tick();
        bus.MAR = 16'h0031; bus.MDR_wr = 16'hAAAA;
        n = 0;
        while (!bus.MEM_RDY && n < 20) begin tick(); n++; end
        check("latch_rdy", 32'(bus.MEM_RDY), 32'd1);
        bus.MEM_WE = 1'b0;
        tick();
        tick();
        check("latch_mem",   32'(mem[16'h0030]), 32'h5555);
        check("latch_other", 32'(mem[16'h0031]), 32'h0000);

        // Request dropped before MEM_RDY still completes
        bus.MAR = 16'h0050; bus.MDR_wr = 16'h0BAD; bus.MEM_WE = 1'b1;
        tick();
        bus.MEM_WE = 1'b0;
        n = 1;
        while (!bus.MEM_RDY && n < 20) begin tick(); n++; end
        check("drop_lat", 32'(n), 32'd2);
        tick();
        tick();
        check("drop_mem", 32'(mem[16'h0050]), 32'h0BAD);

        // IO read of synchronized switches, IO write of hex register
        SW = 10'd26;
        tick(); tick(); tick();
        w0 = we_cnt;
        access(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, rd);
        check("io_rd_lat",  32'(lat), 32'd2);
        check("io_rd_data", 32'(rd), 32'h001A);
        access(1'b1, 1'b0, 16'hFFFF, 16'hC0DE, lat, rd);
        check("io_wr_lat",  32'(lat), 32'd2);
        check("io_hexreg",  32'(HEX_reg), 32'hC0DE);
        check("io_no_ramwe", 32'(we_cnt - w0), 32'd0);
        check("io_hexseg",  32'({HEX3, HEX2, HEX1, HEX0}), 32'(HEX_C0DE));

        // Held request produces exactly one MEM_RDY
        r0 = rdy_cnt;
        bus.MAR = 16'h0010; bus.MEM_OE = 1'b1;
        n = 0;
        while (!bus.MEM_RDY && n < 20) begin tick(); n++; end
        for (int i = 0; i < 10; i++) tick();
        check("hold_one_rdy", 32'(rdy_cnt - r0), 32'd1);
        bus.MEM_OE = 1'b0;
        tick();
        tick();
        access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd);
        check("second_lat",  32'(lat), 32'd4);
        check("second_data", 32'(rd), 32'hBEEF);

        // OE and WE together are a write
        w0 = we_cnt;
        access(1'b1, 1'b1, 16'h0040, 16'h7777, lat, rd);
        check("both_lat", 32'(lat), 32'd2);
        check("both_we",  32'(we_cnt - w0), 32'd1);
        check("both_mem", 32'(mem[16'h0040]), 32'h7777);

        // Reset during RAM_WAIT aborts the access
        r0 = rdy_cnt;
        bus.MAR = 16'h0010; bus.MEM_OE = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        bus.MEM_OE = 1'b0;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        check("abort_mdr",    32'(bus.MDR_rd), 32'h0);
        access(1'b0, 1'b1, 16'h0010, 16'h0000, lat, rd);
        check("post_rst_lat",  32'(lat), 32'd4);
        check("post_rst_data", 32'(rd), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
